lsu_bus_bridge: RTL and testbench
=================================

# lsu_bus_bridge

Load/store bridge sitting directly downstream of the core datapath: it consumes the datapath's `ALUResult` (address), `WriteData` and memory-control strobes, and returns the `ReadData` that the datapath's result mux writes back. It converts each single-cycle memory access into a valid/ready request plus response transaction on a word-wide data bus. It performs byte and halfword lane steering and sign/zero extension, and holds the core with `Stall` until the access completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ+RESP before the access is aborted with `BusError`.
- `CNT_W`, default 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `MemWrite` in 1: current instruction is a store.
- `MemRead` in 1: current instruction is a load.
- `Funct3` in 3: access size/sign, `Instruction[14:12]`.
- `ALUResult` in 32: byte address.
- `WriteData` in 32: store data (rs2).
- `ReadData` out 32: extended load data, valid in DONE.
- `Stall` out 1: freezes PC and register-file write while high.
- `AccessFault` out 1: misaligned address or unsupported `Funct3`.
- `BusError` out 1: one-cycle pulse in DONE when the access timed out.
- `bus_req_valid` out 1, `bus_req_ready` in 1: request handshake.
- `bus_addr` out 32: word address, bits [1:0] = 0.
- `bus_we` out 1: write request.
- `bus_wstrb` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rsp_valid` in 1: read data valid.
- `bus_rdata` in 32: read data.

## Operation
- States: IDLE, REQ, RESP, DONE.
- Access = `MemRead | MemWrite`. If both are high, the access is treated as a store.
- Fault check, combinational in IDLE:
  - LH/LHU/SH with `ALUResult[0]` = 1 faults.
  - LW/SW with `ALUResult[1:0]` ≠ 0 faults.
  - Load `Funct3` outside {000, 001, 010, 100, 101} faults.
  - Store `Funct3` outside {000, 001, 010} faults.
- On a fault: `AccessFault` = 1, `Stall` = 0, no bus request is issued, and the state stays IDLE.
- IDLE with a non-faulting access: latch `bus_addr = {ALUResult[31:2], 2'b00}`, `bus_we`, `bus_wstrb`, `bus_wdata`, `Funct3` and `ALUResult[1:0]`. Then go to REQ.
- Store steering:
  - SB: strobe = `4'b0001 << a[1:0]`, data = byte replicated ×4.
  - SH: strobe = `4'b0011 << a[1:0]`, data = halfword replicated ×2.
  - SW: strobe = `4'b1111`.
- Load strobes are `4'b0000`.
- REQ: `bus_req_valid` = 1, with all request fields held stable until `bus_req_ready`.
  - On handshake, a store goes to DONE.
  - On handshake, a load goes to RESP.
- RESP: wait for `bus_rsp_valid`. Capture `bus_rdata`, select the byte/halfword at the latched `a[1:0]`, sign-extend (LB/LH) or zero-extend (LBU/LHU) into `ReadData`, then go to DONE.
- DONE: lasts one cycle, then returns to IDLE. The core commits on the edge leaving DONE.
- Timeout:
  - The counter clears on entering REQ and increments in REQ and RESP.
  - When it reaches TIMEOUT_CYCLES, go to DONE with `ReadData` = 0 and `BusError` = 1.
  - If `bus_req_valid` was still high, it drops.
- `bus_rsp_valid` outside RESP is ignored.

## Timing
- `Stall` = (IDLE & access & !fault) | REQ | RESP. It is combinational, so it is high in the same cycle the access appears.
- DONE has `Stall` = 0, so each access holds the instruction for exactly one extra cycle after completion. No re-trigger occurs because the PC advances at the end of DONE.
- Minimum latency with zero-wait-state ready/response:
  - Store: IDLE → REQ → DONE, 3 cycles total.
  - Load: IDLE → REQ → RESP → DONE, 4 cycles total.
- `ReadData` is registered; it updates on entry to DONE and holds until the next load's DONE.
- Reset values: state IDLE, `bus_req_valid` 0, `bus_we` 0, `bus_wstrb` 0, `bus_addr` 0, `bus_wdata` 0, `ReadData` 0, `BusError` 0, counter 0.
- `Stall` and `AccessFault` reset to 0 given inactive inputs.
- Reset mid-transaction: abort at the next edge. `bus_req_valid` is low the cycle after reset is sampled, and a late `bus_rsp_valid` is ignored.
- Simultaneous `bus_req_ready` and timeout expiry in REQ: the handshake wins.
- Simultaneous `bus_rsp_valid` and timeout expiry in RESP: the response wins and `BusError` = 0.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, ready held high → `bus_addr` 0x100, `bus_wstrb` 1111, `bus_wdata` 0xDEADBEEF, `Stall` high for 2 cycles, `ReadData` unchanged.
- SB to 0x203 with data 0x000000A5 → `bus_addr` 0x200, `bus_wstrb` 1000, `bus_wdata` 0xA5A5A5A5.
- LB/LBU/LH/LHU/LW from 0x42/0x42/0x42/0x42/0x40 with `bus_rdata` 0x80FF7F01, response 1 cycle after handshake:
  - LB/LBU read the byte at lane 2 (0xFF) and give 0xFFFFFFFF / 0x000000FF.
  - LH/LHU read the halfword at 0x42 (0x80FF) and give 0xFFFF80FF / 0x000080FF.
  - LW gives 0x80FF7F01.
  - Each access stalls for 3 cycles.
- LW at 0x102 and SH at 0x11 → `AccessFault` 1, `Stall` 0, `bus_req_valid` never asserted.
- LW with `bus_req_ready` held 0 and TIMEOUT_CYCLES = 8 → `bus_req_valid` high for 8 cycles, then DONE with `BusError` pulse and `ReadData` 0.
- Reset (0) asserted in RESP → next cycle IDLE, all outputs at reset values, and a later `bus_rsp_valid` does not change `ReadData`.

Source files
------------

// File: rtl/lsu_bus_bridge.sv
// ============================================================================
// Module   : lsu_bus_bridge
// Brief    : Load/store bridge turning single-cycle core memory accesses into
//            valid/ready bus transactions with lane steering and extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessFault,
    output logic        BusError,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic              r_req_valid;
    logic              r_we;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_bus_err;

    logic              w_access;
    logic              w_store;
    logic              w_fault;
    logic              w_idle;
    logic              w_timeout;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_ext;

    assign w_access  = MemRead | MemWrite;
    assign w_store   = MemWrite;
    assign w_idle    = (r_state == S_IDLE);
    assign w_timeout = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_fault = 1'b0;
        if (w_store) begin
            case (Funct3)
                3'b000:  w_fault = 1'b0;
                3'b001:  w_fault = ALUResult[0];
                3'b010:  w_fault = |ALUResult[1:0];
                default: w_fault = 1'b1;
            endcase
        end else begin
            case (Funct3)
                3'b000, 3'b100: w_fault = 1'b0;
                3'b001, 3'b101: w_fault = ALUResult[0];
                3'b010:         w_fault = |ALUResult[1:0];
                default:        w_fault = 1'b1;
            endcase
        end
    end

    // Store lanes: replicate narrow data so the strobes pick the right copy.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = WriteData;
        if (w_store) begin
            case (Funct3)
                3'b000: begin
                    w_wstrb = 4'b0001 << ALUResult[1:0];
                    w_wdata = {4{WriteData[7:0]}};
                end
                3'b001: begin
                    w_wstrb = 4'b0011 << ALUResult[1:0];
                    w_wdata = {2{WriteData[15:0]}};
                end
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_wstrb     <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access && !w_fault) begin
                        r_state     <= S_REQ;
                        r_cnt       <= '0;
                        r_req_valid <= 1'b1;
                        r_addr      <= {ALUResult[31:2], 2'b00};
                        r_we        <= w_store;
                        r_wstrb     <= w_wstrb;
                        r_wdata     <= w_wdata;
                        r_funct3    <= Funct3;
                        r_off       <= ALUResult[1:0];
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A handshake on the final timeout cycle still completes.
                    if (bus_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= r_we ? S_DONE : S_RESP;
                    end else if (w_timeout) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_DONE;
                        r_rdata     <= 32'd0;
                        r_bus_err   <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_rsp_valid) begin
                        r_state <= S_DONE;
                        r_rdata <= w_load_ext;
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        r_rdata   <= 32'd0;
                        r_bus_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Stall         = (w_idle && w_access && !w_fault) ||
                           (r_state == S_REQ) || (r_state == S_RESP);
    assign AccessFault   = w_idle && w_access && w_fault;
    assign ReadData      = r_rdata;
    assign BusError      = r_bus_err;
    assign bus_req_valid = r_req_valid;
    assign bus_addr      = r_addr;
    assign bus_we        = r_we;
    assign bus_wstrb     = r_wstrb;
    assign bus_wdata     = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_bridge.sv
// ============================================================================
// Module   : tb_lsu_bus_bridge
// Brief    : Directed self-checking bench for lsu_bus_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, AccessFault, BusError;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    int          g_stall, g_valid;
    logic [31:0] g_addr, g_wdata, g_rdata;
    logic [3:0]  g_wstrb;
    logic        g_we, g_berr;

    lsu_bus_bridge #(.TIMEOUT_CYCLES(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset),
        .MemWrite(MemWrite), .MemRead(MemRead), .Funct3(Funct3),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault),
        .BusError(BusError),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access from IDLE to DONE; the bus answers one cycle after a handshake.
    task automatic do_access(input logic wr, input logic rd, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdat,
                             input logic rdy, input logic [31:0] rdat);
        logic hs;
        logic done;
        MemWrite = wr; MemRead = rd; Funct3 = f3;
        ALUResult = addr; WriteData = wdat;
        bus_req_ready = rdy; bus_rdata = rdat;
        hs = 1'b0; done = 1'b0;
        g_stall = 0; g_valid = 0;
        g_addr = 'x; g_wdata = 'x; g_wstrb = 'x; g_we = 1'bx;
        for (int i = 0; i < 40 && !done; i++) begin
            bus_rsp_valid = hs;
            #1;
            if (Stall) g_stall++;
            else done = 1'b1;
            if (bus_req_valid) begin
                g_valid++;
                g_addr = bus_addr; g_wdata = bus_wdata;
                g_wstrb = bus_wstrb; g_we = bus_we;
            end
            hs = bus_req_valid & bus_req_ready;
            if (!done) step();
        end
        check("access_completes", {31'd0, done}, 32'd1);
        g_rdata = ReadData;
        g_berr  = BusError;
        MemWrite = 1'b0; MemRead = 1'b0; bus_rsp_valid = 1'b0;
        step();
    endtask

    task automatic check_load(input string tag, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] exp);
        do_access(1'b0, 1'b1, f3, addr, 32'h0, 1'b1, 32'h80FF7F01);
        check({tag, "_data"}, g_rdata, exp);
        check({tag, "_stall"}, g_stall, 3);
        check({tag, "_addr"}, g_addr, 32'h40);
        check({tag, "_wstrb"}, {28'd0, g_wstrb}, 32'd0);
    endtask

    task automatic check_fault(input string tag, input logic wr, input logic rd,
                               input logic [2:0] f3, input logic [31:0] addr);
        int seen;
        MemWrite = wr; MemRead = rd; Funct3 = f3; ALUResult = addr;
        bus_req_ready = 1'b1;
        #1;
        check({tag, "_fault"}, {31'd0, AccessFault}, 32'd1);
        check({tag, "_stall"}, {31'd0, Stall}, 32'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus_req_valid) seen++;
        end
        check({tag, "_no_req"}, seen, 0);
        MemWrite = 1'b0; MemRead = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Funct3 = 3'd0;
        ALUResult = 32'd0; WriteData = 32'd0; bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0; bus_rdata = 32'd0;
        step();
        step();
        check("rst_valid", {31'd0, bus_req_valid}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_we", {31'd0, bus_we}, 32'd0);
        check("rst_rdata", ReadData, 32'd0);
        check("rst_berr", {31'd0, BusError}, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_fault", {31'd0, AccessFault}, 32'd0);
        reset = 1'b1;
        step();

        check_load("lb",  3'b000, 32'h42, 32'hFFFFFFFF);
        check_load("lbu", 3'b100, 32'h42, 32'h000000FF);
        check_load("lh",  3'b001, 32'h42, 32'hFFFF80FF);
        check_load("lhu", 3'b101, 32'h42, 32'h000080FF);
        check_load("lw",  3'b010, 32'h40, 32'h80FF7F01);

        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0);
        check("sw_addr", g_addr, 32'h100);
        check("sw_wstrb", {28'd0, g_wstrb}, 32'hF);
        check("sw_wdata", g_wdata, 32'hDEADBEEF);
        check("sw_we", {31'd0, g_we}, 32'd1);
        check("sw_stall", g_stall, 2);
        check("sw_rdata_held", g_rdata, 32'h80FF7F01);

        do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h000000A5, 1'b1, 32'h0);
        check("sb_addr", g_addr, 32'h200);
        check("sb_wstrb", {28'd0, g_wstrb}, 32'h8);
        check("sb_wdata", g_wdata, 32'hA5A5A5A5);

        do_access(1'b1, 1'b0, 3'b001, 32'h12, 32'hFFFF1234, 1'b1, 32'h0);
        check("sh_wstrb", {28'd0, g_wstrb}, 32'hC);
        check("sh_wdata", g_wdata, 32'h12341234);

        check_fault("lw_mis", 1'b0, 1'b1, 3'b010, 32'h102);
        check_fault("sh_mis", 1'b1, 1'b0, 3'b001, 32'h11);
        check_fault("ld_f3", 1'b0, 1'b1, 3'b011, 32'h40);

        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 1'b0, 32'h12345678);
        check("tmo_valid_cycles", g_valid, 8);
        check("tmo_stall", g_stall, 9);
        check("tmo_berr", {31'd0, g_berr}, 32'd1);
        check("tmo_rdata", g_rdata, 32'd0);
        check("tmo_berr_pulse", {31'd0, BusError}, 32'd0);

        // Reset while waiting for the read response.
        do_access(1'b0, 1'b1, 3'b100, 32'h41, 32'h0, 1'b1, 32'h80FF7F01);
        check("pre_rst_rdata", g_rdata, 32'h0000007F);
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h40;
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
        step();
        step();
        check("resp_stall", {31'd0, Stall}, 32'd1);
        reset = 1'b0; MemRead = 1'b0;
        step();
        check("mid_rst_valid", {31'd0, bus_req_valid}, 32'd0);
        check("mid_rst_rdata", ReadData, 32'd0);
        check("mid_rst_addr", bus_addr, 32'd0);
        check("mid_rst_stall", {31'd0, Stall}, 32'd0);
        reset = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 32'hCAFEF00D;
        step();
        bus_rsp_valid = 1'b0;
        step();
        check("late_rsp_rdata", ReadData, 32'd0);
        check("late_rsp_stall", {31'd0, Stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
